// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one outstanding imem request at a time,
// holds the returned word for decode and handles redirects at any point.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [6:0]  if_opcode
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OPC_W  = 7;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;
  localparam logic [XLEN-1:0] ALIGN_MSK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    DROP  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] req_pc, req_pc_n;
  logic            if_valid_n;
  logic [XLEN-1:0] if_instr_n, if_pc_n;
  logic            imem_req_n;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_pc   <= '0;
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      if_pc    <= '0;
      imem_req <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      req_pc   <= req_pc_n;
      if_valid <= if_valid_n;
      if_instr <= if_instr_n;
      if_pc    <= if_pc_n;
      imem_req <= imem_req_n;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_pc_n   = req_pc;
    if_valid_n = if_valid;
    if_instr_n = if_instr;
    if_pc_n    = if_pc;

    unique case (state)
      IDLE: state_n = FETCH;

      FETCH: begin
        if (redirect_valid) begin
          // An accepted request now targets the wrong pc; its response must be dropped.
          state_n = imem_ready ? DROP : FETCH;
        end else if (imem_ready) begin
          req_pc_n = pc;
          state_n  = WAIT;
        end
      end

      WAIT: begin
        if (redirect_valid) begin
          state_n = imem_rvalid ? FETCH : DROP;
        end else if (imem_rvalid) begin
          if_instr_n = imem_rdata;
          if_pc_n    = req_pc;
          if_valid_n = 1'b1;
          pc_n       = req_pc + PC_STEP;
          state_n    = HOLD;
        end
      end

      DROP: begin
        if (imem_rvalid) state_n = FETCH;
      end

      HOLD: begin
        if (redirect_valid || id_ready) begin
          if_valid_n = 1'b0;
          state_n    = FETCH;
        end
      end

      default: state_n = IDLE;
    endcase

    // Redirect always wins the pc, regardless of state
    if (redirect_valid) pc_n = redirect_pc & ALIGN_MSK;
  end

  assign imem_req_n = (state_n == FETCH);
  assign imem_addr  = pc;
  assign if_opcode  = if_instr[OPC_W-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a transaction-level reference model
// compared on every falling edge, plus literal spot checks.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [6:0]  if_opcode;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_opcode      (if_opcode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transaction-level model: started / requesting / outstanding(+stale) / holding
  logic        m_started, m_out, m_stale, m_hold;
  logic [31:0] m_pc, m_req_addr, m_instr, m_ifpc;

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] tgt;
    if (!rst_n) begin
      m_started  = 1'b0;
      m_out      = 1'b0;
      m_stale    = 1'b0;
      m_hold     = 1'b0;
      m_pc       = RST_PC;
      m_req_addr = 32'h0;
      m_instr    = NOP;
      m_ifpc     = 32'h0;
    end else begin
      tgt = {redirect_pc[31:2], 2'b00};
      if (!m_started) begin
        m_started = 1'b1;
      end else if (m_hold) begin
        if (redirect_valid || id_ready) m_hold = 1'b0;
      end else if (m_out) begin
        if (imem_rvalid) begin
          if (!m_stale && !redirect_valid) begin
            m_hold  = 1'b1;
            m_instr = imem_rdata;
            m_ifpc  = m_req_addr;
            m_pc    = m_req_addr + 32'd4;
          end
          m_out   = 1'b0;
          m_stale = 1'b0;
        end else if (redirect_valid) begin
          m_stale = 1'b1;
        end
      end else if (imem_ready) begin
        m_out      = 1'b1;
        m_req_addr = m_pc;
        m_stale    = redirect_valid;
      end
      if (redirect_valid) m_pc = tgt;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    logic exp_req;
    exp_req = m_started && !m_out && !m_hold;
    chk("cmp_if_valid", 32'(if_valid), 32'(m_hold));
    chk("cmp_imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("cmp_imem_addr", imem_addr, m_pc);
    chk("cmp_if_instr", if_instr, m_instr);
    chk("cmp_if_pc", if_pc, m_ifpc);
    chk("cmp_if_opcode", 32'(if_opcode), 32'(m_instr[6:0]));
  end

  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rd,
                     input logic idr, input logic rr, input logic [31:0] rp);
    imem_ready     = rdy;
    imem_rvalid    = rv;
    imem_rdata     = rd;
    id_ready       = idr;
    redirect_valid = rr;
    redirect_pc    = rp;
    @(posedge clk);
    #1;
    imem_ready     = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_if_valid"}, 32'(if_valid), 32'h0);
    chk({tag, "_if_instr"}, if_instr, 32'h0000_0013);
    chk({tag, "_if_pc"}, if_pc, 32'h0);
    chk({tag, "_imem_req"}, 32'(imem_req), 32'h0);
    chk({tag, "_if_opcode"}, 32'(if_opcode), 32'h13);
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_ready     = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    chk("idle_no_req", 32'(imem_req), 32'h0);

    // First fetch after release, zero-wait memory
    cyc(0, 0, 32'h0, 0, 0, 32'h0);
    chk("first_req", 32'(imem_req), 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    cyc(1, 0, 32'h0, 0, 0, 32'h0);
    chk("wait_no_req", 32'(imem_req), 32'h0);
    cyc(0, 1, 32'h0010_0093, 0, 0, 32'h0);
    chk("hold_valid", 32'(if_valid), 32'h1);
    chk("hold_pc", if_pc, 32'h0);
    chk("hold_instr", if_instr, 32'h0010_0093);
    chk("hold_opcode", 32'(if_opcode), 32'h13);

    // Decode stall
    repeat (5) cyc(0, 0, 32'h0, 0, 0, 32'h0);
    chk("stall_instr", if_instr, 32'h0010_0093);
    chk("stall_req", 32'(imem_req), 32'h0);
    cyc(0, 0, 32'h0, 1, 0, 32'h0);
    chk("next_addr4", imem_addr, 32'h4);
    chk("consumed", 32'(if_valid), 32'h0);

    // Memory back-pressure then two-cycle response
    repeat (3) cyc(0, 0, 32'h0, 0, 0, 32'h0);
    chk("bp_req", 32'(imem_req), 32'h1);
    chk("bp_addr", imem_addr, 32'h4);
    cyc(1, 0, 32'h0, 0, 0, 32'h0);
    cyc(0, 0, 32'h0, 0, 0, 32'h0);
    cyc(0, 1, 32'h0020_8113, 0, 0, 32'h0);
    chk("slow_pc", if_pc, 32'h4);
    cyc(0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0);
    chk("rvalid_in_hold_ignored", if_instr, 32'h0020_8113);
    cyc(0, 0, 32'h0, 1, 0, 32'h0);
    chk("addr8", imem_addr, 32'h8);

    // Redirect while waiting: response discarded
    cyc(1, 0, 32'h0, 0, 0, 32'h0);
    cyc(0, 0, 32'h0, 0, 1, 32'h0000_0102);
    chk("drop_no_req", 32'(imem_req), 32'h0);
    cyc(0, 1, 32'h1111_1111, 0, 0, 32'h0);
    chk("drop_valid", 32'(if_valid), 32'h0);
    chk("drop_next_addr", imem_addr, 32'h100);
    chk("drop_instr_kept", if_instr, 32'h0020_8113);

    // Redirect on the accepting cycle
    cyc(1, 0, 32'h0, 0, 1, 32'h0000_0100);
    chk("acc_redir_no_req", 32'(imem_req), 32'h0);
    cyc(0, 0, 32'h0, 0, 0, 32'h0);
    cyc(0, 1, 32'h2222_2222, 0, 0, 32'h0);
    chk("acc_redir_addr", imem_addr, 32'h100);
    chk("acc_redir_valid", 32'(if_valid), 32'h0);

    // Redirect in FETCH without ready, and pc wrap
    cyc(0, 0, 32'h0, 0, 1, 32'hFFFF_FFFF);
    chk("redir_fetch_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(1, 0, 32'h0, 0, 0, 32'h0);
    cyc(0, 1, 32'h0000_0033, 0, 0, 32'h0);
    chk("top_pc", if_pc, 32'hFFFF_FFFC);
    chk("top_opcode", 32'(if_opcode), 32'h33);
    cyc(0, 0, 32'h0, 1, 0, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);

    // Redirect coincident with response in WAIT
    cyc(1, 0, 32'h0, 0, 0, 32'h0);
    cyc(0, 1, 32'h3333_3333, 0, 1, 32'h0000_0040);
    chk("wait_rv_redir_valid", 32'(if_valid), 32'h0);
    chk("wait_rv_redir_addr", imem_addr, 32'h40);

    // Redirect in HOLD without id_ready
    cyc(1, 0, 32'h0, 0, 0, 32'h0);
    cyc(0, 1, 32'h0040_0093, 0, 0, 32'h0);
    chk("hold40_pc", if_pc, 32'h40);
    cyc(0, 0, 32'h0, 0, 1, 32'h0000_0080);
    chk("hold_redir_valid", 32'(if_valid), 32'h0);
    chk("hold_redir_addr", imem_addr, 32'h80);

    // Asynchronous reset in WAIT, late response afterwards
    cyc(1, 0, 32'h0, 0, 0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 1, 32'h4444_4444, 0, 0, 32'h0);
    cyc(0, 1, 32'h5555_5555, 0, 0, 32'h0);
    chk("post_rst_valid", 32'(if_valid), 32'h0);
    chk("post_rst_addr", imem_addr, RST_PC);
    cyc(1, 0, 32'h0, 0, 0, 32'h0);
    cyc(0, 1, 32'h0050_0093, 0, 0, 32'h0);
    chk("post_rst_instr", if_instr, 32'h0050_0093);
    chk("post_rst_pc", if_pc, 32'h0);
    cyc(0, 0, 32'h0, 1, 0, 32'h0);
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
